// File: rtl/m_dm_rmw_ctrl.sv
// m_dm_rmw_ctrl: maps M-stage loads, word stores and partial stores onto a
// word-only memory port. Partial stores go through read-modify-write. The
// pipeline is stalled until the access completes, and read timeouts raise a
// sticky error flag.
module m_dm_rmw_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [31:0]       cpu_addr,
    input  logic [3:0]        cpu_byteen,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        RESP     = 3'd4
    } state_t;

    // Last counter value allowed in RD_WAIT before the read is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        byteen_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [7:0]        tmo_cnt;
    logic              rd_hit;
    logic              tmo_hit;
    logic              is_load_q;
    logic              is_word_q;
    logic              unused_addr_bits;

    // Byte-lane merge: new store bytes where enabled, old memory bytes elsewhere.
    function automatic logic [31:0] merge_bytes(input logic [3:0]  be,
                                                input logic [31:0] wd,
                                                input logic [31:0] rd);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? wd[8*i +: 8] : rd[8*i +: 8];
        end
        return m;
    endfunction

    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    assign is_load_q = (byteen_q == 4'h0);
    assign is_word_q = (byteen_q == 4'hF);
    // A return arriving on the timeout cycle wins, so timeout requires !rvalid.
    assign rd_hit    = (state == RD_WAIT) && mem_rvalid;
    assign tmo_hit   = (state == RD_WAIT) && !mem_rvalid && (tmo_cnt == TMO_LAST);

    assign mem_addr  = addr_q;
    assign mem_wdata = is_word_q ? wdata_q : merge_q;

    // Control state: FSM register, timeout counter, sticky error, load data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tmo_cnt   <= 8'd0;
            err       <= 1'b0;
            cpu_rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == RD_ISSUE) begin
                tmo_cnt <= 8'd0;
            end else if ((state == RD_WAIT) && !mem_rvalid && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (tmo_hit) begin
                err       <= 1'b1;
                cpu_rdata <= 32'd0;
            end else if (rd_hit && is_load_q) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    // Request capture and merged write word; data path, no reset needed.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && cpu_req) begin
            addr_q   <= cpu_addr[ADDR_W+1:2];
            byteen_q <= cpu_byteen;
            wdata_q  <= cpu_wdata;
        end
        if (rd_hit && !is_load_q) begin
            merge_q <= merge_bytes(byteen_q, wdata_q, mem_rdata);
        end
    end

    // Next-state decode and per-state memory/pipeline strobes.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_done  = 1'b0;
        cpu_stall = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    cpu_stall = 1'b1;
                    state_nxt = (cpu_byteen == 4'hF) ? WR_ISSUE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                mem_en    = 1'b1;
                cpu_stall = 1'b1;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                cpu_stall = 1'b1;
                if (mem_rvalid) begin
                    state_nxt = is_load_q ? RESP : WR_ISSUE;
                end else if (tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            WR_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                cpu_stall = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                cpu_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_m_dm_rmw_ctrl.sv
// Directed bench for m_dm_rmw_ctrl with TIMEOUT=4.
module tb_m_dm_rmw_ctrl;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic [31:0]       cpu_addr;
    logic [3:0]        cpu_byteen;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_done;
    logic              cpu_stall;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int wr_base  = 0;

    m_dm_rmw_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_byteen (cpu_byteen),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .cpu_stall  (cpu_stall),
        .err        (err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write commands seen on the memory port, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_en && mem_we) wr_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        cpu_req    = 1'b1;
        cpu_addr   = a;
        cpu_byteen = be;
        cpu_wdata  = wd;
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_byteen = '0; cpu_wdata = '0;
        mem_rdata = '0; mem_rvalid = 1'b0;
        tick; tick; #1;
        chk("rst_done", cpu_done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_stall", cpu_stall, 0);
        reset = 1'b0;

        // Word store
        tick; wr_base = wr_cnt; req(32'h10, 4'hF, 32'hDEADBEEF); #1;
        chk("ws_T_stall", cpu_stall, 1);
        chk("ws_T_en", mem_en, 0);
        tick; #1;
        chk("ws_T1_en", mem_en, 1);
        chk("ws_T1_we", mem_we, 1);
        chk("ws_T1_addr", mem_addr, 10'd4);
        chk("ws_T1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("ws_T1_stall", cpu_stall, 1);
        chk("ws_T1_done", cpu_done, 0);
        tick; cpu_req = 1'b0; #1;
        chk("ws_T2_done", cpu_done, 1);
        chk("ws_T2_stall", cpu_stall, 0);
        chk("ws_T2_en", mem_en, 0);
        tick; #1;
        chk("ws_T3_done", cpu_done, 0);
        chk("ws_wr_count", wr_cnt - wr_base, 1);

        // Load, rvalid three cycles after the read
        tick; wr_base = wr_cnt; req(32'h8, 4'h0, 32'h0); #1;
        tick; #1;
        chk("ld_rd_en", mem_en, 1);
        chk("ld_rd_we", mem_we, 0);
        chk("ld_rd_addr", mem_addr, 10'd2);
        tick; #1;
        chk("ld_wait_en", mem_en, 0);
        chk("ld_wait_stall", cpu_stall, 1);
        tick; #1;
        tick; mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
        chk("ld_rv_done", cpu_done, 0);
        tick; mem_rvalid = 1'b0; mem_rdata = 32'h0; cpu_req = 1'b0; #1;
        chk("ld_done", cpu_done, 1);
        chk("ld_rdata", cpu_rdata, 32'h12345678);
        chk("ld_stall", cpu_stall, 0);
        tick; #1;
        chk("ld_no_write", wr_cnt - wr_base, 0);

        // Partial store, single byte lane
        tick; wr_base = wr_cnt; req(32'h20, 4'b0100, 32'h00AB0000); #1;
        tick; #1;
        chk("ps_rd_en", mem_en, 1);
        chk("ps_rd_we", mem_we, 0);
        chk("ps_rd_addr", mem_addr, 10'd8);
        tick; mem_rvalid = 1'b1; mem_rdata = 32'h11223344; #1;
        tick; mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
        chk("ps_wr_en", mem_en, 1);
        chk("ps_wr_we", mem_we, 1);
        chk("ps_wr_addr", mem_addr, 10'd8);
        chk("ps_wr_data", mem_wdata, 32'h11AB3344);
        chk("ps_wr_done", cpu_done, 0);
        tick; cpu_req = 1'b0; #1;
        chk("ps_done", cpu_done, 1);
        chk("ps_resp_en", mem_en, 0);
        tick; #1;
        chk("ps_wr_count", wr_cnt - wr_base, 1);

        // Non-contiguous partial store, rvalid two cycles after read
        tick; wr_base = wr_cnt; req(32'h24, 4'b1001, 32'hAA0000BB); #1;
        tick; #1;
        chk("nc_rd_addr", mem_addr, 10'd9);
        tick; #1;
        tick; mem_rvalid = 1'b1; mem_rdata = 32'h11223344; #1;
        tick; mem_rvalid = 1'b0; #1;
        chk("nc_wr_we", mem_we, 1);
        chk("nc_wr_data", mem_wdata, 32'hAA2233BB);
        tick; cpu_req = 1'b0; #1;
        chk("nc_done", cpu_done, 1);
        tick; #1;

        // Timeout: four RD_WAIT cycles with no return
        tick; wr_base = wr_cnt; req(32'h30, 4'h0, 32'h0); #1;
        tick; #1;
        chk("to_rd_addr", mem_addr, 10'd12);
        tick; #1;
        tick; #1;
        tick; #1;
        tick; #1;
        chk("to_last_wait_done", cpu_done, 0);
        chk("to_last_wait_err", err, 0);
        chk("to_last_wait_stall", cpu_stall, 1);
        tick; cpu_req = 1'b0; #1;
        chk("to_done", cpu_done, 1);
        chk("to_err", err, 1);
        chk("to_rdata", cpu_rdata, 0);
        tick; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF; #1;
        chk("to_late_err", err, 1);
        chk("to_late_done", cpu_done, 0);
        chk("to_late_en", mem_en, 0);
        tick; mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
        chk("to_late_rdata", cpu_rdata, 0);
        chk("to_late_en2", mem_en, 0);
        chk("to_no_write", wr_cnt - wr_base, 0);

        // rvalid on the final wait cycle beats the timeout
        tick; req(32'h34, 4'h0, 32'h0); #1;
        tick; #1;
        tick; #1;
        tick; #1;
        tick; #1;
        tick; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
        tick; mem_rvalid = 1'b0; mem_rdata = 32'h0; cpu_req = 1'b0; #1;
        chk("race_done", cpu_done, 1);
        chk("race_rdata", cpu_rdata, 32'hCAFEF00D);
        chk("race_err_sticky", err, 1);
        tick; #1;

        // Reset during RD_WAIT of a partial store, then a clean retry
        tick; wr_base = wr_cnt; req(32'h40, 4'b0011, 32'h00005566); #1;
        tick; #1;
        chk("rr_rd_addr", mem_addr, 10'd16);
        tick; reset = 1'b1; cpu_req = 1'b0; #1;
        tick; reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344; #1;
        chk("rr_err", err, 0);
        chk("rr_rdata", cpu_rdata, 0);
        chk("rr_done", cpu_done, 0);
        chk("rr_en", mem_en, 0);
        chk("rr_we", mem_we, 0);
        chk("rr_stall", cpu_stall, 0);
        tick; mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
        chk("rr_stale_en", mem_en, 0);
        chk("rr_stale_done", cpu_done, 0);
        tick; #1;
        chk("rr_no_write", wr_cnt - wr_base, 0);
        req(32'h40, 4'b0011, 32'h00005566); #1;
        tick; #1;
        chk("rr2_rd_en", mem_en, 1);
        chk("rr2_rd_we", mem_we, 0);
        tick; mem_rvalid = 1'b1; mem_rdata = 32'h11223344; #1;
        tick; mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
        chk("rr2_wr_we", mem_we, 1);
        chk("rr2_wr_addr", mem_addr, 10'd16);
        chk("rr2_wr_data", mem_wdata, 32'h11225566);
        tick; cpu_req = 1'b0; #1;
        chk("rr2_done", cpu_done, 1);
        tick; #1;
        chk("rr2_wr_count", wr_cnt - wr_base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
